// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and constants for the scanning decoder
// Holds the FSM state encoding and the width of the blanking counter,
// which is sized for the largest legal BLANK_CYC (15).
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int BLANK_CNT_W = 4;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational N-to-2**N one-hot decoder
// Ports:
//   addr [N-1:0]     address to decode
//   en               when low, all outputs are zero
//   y    [2**N-1:0]  one-hot result (bit addr set when en is high)
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]      addr,
  input  logic              en,
  output logic [2**N-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) y[addr] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - one-hot select driver with direct and scanning modes
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   en                enable; low returns to idle with no select driven
//   mode              0 = drive the decode of addr, 1 = walk all addresses
//   addr  [N-1:0]     direct-mode address
//   dwell [DWELL_W-1:0] scan hold time, each address held dwell+1 cycles
//   y     [2**N-1:0]  registered one-hot select, zero when idle or blanking
//   cur_addr [N-1:0]  address currently or last driven
//   wrap              pulses on the final drive cycle of the last scan address
//   active            high exactly when y is non-zero
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N         = 3,
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    y,
  output logic [N-1:0]       cur_addr,
  output logic               wrap,
  output logic               active
);

  localparam logic [BLANK_CNT_W-1:0] BLANK_LAST = BLANK_CNT_W'(BLANK_CYC - 1);

  state_t                 state, nxt_state;
  logic [N-1:0]           next_addr, nxt_cur, nxt_next;
  logic                   mode_q, nxt_mode;
  logic [DWELL_W-1:0]     dwell_cnt, nxt_dwell;
  logic [BLANK_CNT_W-1:0] blank_cnt, nxt_blank;
  logic [2**N-1:0]        y_nxt;

  // mode_q remembers the mode the current drive phase belongs to, so a mode
  // flip during DRIVE can be detected and forced through a blanking gap.
  always_comb begin
    nxt_state = state;
    nxt_cur   = cur_addr;
    nxt_next  = next_addr;
    nxt_mode  = mode_q;
    nxt_dwell = dwell_cnt;
    nxt_blank = blank_cnt;
    if (!en) begin
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = DRIVE;
          nxt_cur   = mode ? '0 : addr;
          nxt_mode  = mode;
          nxt_dwell = '0;
        end
        DRIVE: begin
          if (mode != mode_q) begin
            nxt_state = BLANK;
            nxt_next  = mode ? '0 : addr;
            nxt_mode  = mode;
            nxt_blank = '0;
          end else if (!mode_q) begin
            if (addr != cur_addr) begin
              nxt_state = BLANK;
              nxt_next  = addr;
              nxt_blank = '0;
            end
          end else if (dwell_cnt == dwell) begin
            nxt_state = BLANK;
            nxt_next  = cur_addr + 1'b1;
            nxt_blank = '0;
          end else begin
            nxt_dwell = dwell_cnt + 1'b1;
          end
        end
        BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            nxt_state = DRIVE;
            nxt_cur   = next_addr;
            nxt_dwell = '0;
          end else begin
            nxt_blank = blank_cnt + 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Decode the address that will be driven next cycle so y can be registered
  // and still appear one clock after the decision.
  onehot_dec #(.N(N)) u_dec (
    .addr (nxt_cur),
    .en   (nxt_state == DRIVE),
    .y    (y_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      next_addr <= '0;
      mode_q    <= 1'b0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      y         <= '0;
      active    <= 1'b0;
    end else begin
      state     <= nxt_state;
      cur_addr  <= nxt_cur;
      next_addr <= nxt_next;
      mode_q    <= nxt_mode;
      dwell_cnt <= nxt_dwell;
      blank_cnt <= nxt_blank;
      y         <= y_nxt;
      active    <= (nxt_state == DRIVE);
    end
  end

  // The last drive cycle of the top address is the one where the dwell
  // comparison succeeds; an enable drop or mode flip cancels the pass.
  assign wrap = (state == DRIVE) && en && mode && mode_q &&
                (&cur_addr) && (dwell_cnt == dwell);

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 3: address width; output width is 2**N.
REQ-002 Parameter DWELL_W, default 8: width of the dwell count.
REQ-003 Parameter BLANK_CYC, default 1 (legal range 1..15): number of all-zero cycles inserted between two active selections.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-006 en  in  1  enable; when 0 the block returns to idle and drives no select line.
REQ-007 mode  in  1  0 selects direct mode (decode addr); 1 selects scan mode (walk all addresses).
REQ-008 addr  in  N  address to decode in direct mode; ignored in scan mode.
REQ-009 dwell  in  DWELL_W  scan-mode hold time; each address is driven for dwell+1 cycles.
REQ-010 y  out  2**N  registered one-hot select; all zeros when idle or blanking.
REQ-011 cur_addr  out  N  address currently or last driven, registered.
REQ-012 wrap  out  1  single-cycle pulse that marks completion of a full scan pass.
REQ-013 active  out  1  high exactly when y is non-zero.

Function
REQ-014 The block SHALL implement the states IDLE, DRIVE and BLANK.
REQ-015 In IDLE, y SHALL be 0; en=1 SHALL move the block to DRIVE on the next edge, with cur_addr=addr when mode=0 and cur_addr=0 when mode=1.
REQ-016 Latency from sampling en=1 in IDLE to the one-hot value on y SHALL be exactly one clock.
REQ-017 In DRIVE, y SHALL equal the one-hot of cur_addr, with bit cur_addr set and all other bits clear.
REQ-018 In direct-mode DRIVE, a sampled addr different from cur_addr SHALL latch addr as the next address and move the block to BLANK.
REQ-019 In direct-mode DRIVE, an unchanged addr SHALL keep the block in DRIVE indefinitely.
REQ-020 In scan-mode DRIVE, the dwell counter SHALL start at 0 on entry and increment each cycle.
REQ-021 When the dwell counter equals the sampled dwell value, the block SHALL move to BLANK with next address = cur_addr+1 modulo 2**N.
REQ-022 wrap SHALL pulse for one cycle, coincident with the last DRIVE cycle, when cur_addr = 2**N-1 in scan mode; wrap SHALL be 0 in all other cycles.
REQ-023 BLANK SHALL hold y=0 for exactly BLANK_CYC cycles, then enter DRIVE with cur_addr set to the latched next address.
REQ-024 en=0 SHALL take priority over every other condition and move the block to IDLE from any state on the next edge.
REQ-025 A mode change while in DRIVE SHALL move the block to BLANK; the next address SHALL be addr for a change to direct mode and 0 for a change to scan mode.
REQ-026 An addr change during BLANK SHALL be ignored until DRIVE is re-entered, at which point it is compared as in REQ-018.
REQ-027 A change to dwell SHALL take effect on the next comparison.
REQ-028 dwell=0 SHALL give one DRIVE cycle per address.
REQ-029 y SHALL never have more than one bit set, including across state transitions (break-before-make).
REQ-030 cur_addr SHALL retain its value through BLANK and IDLE.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state=IDLE, y=0, cur_addr=0, wrap=0, active=0, and dwell counter=0, including mid-scan or mid-blank.
REQ-032 After rst_n is deasserted, the first state change SHALL occur on the first rising edge at which en=1 is sampled.

Structure
REQ-033 Package decoder_pkg SHALL hold the state enumeration (IDLE/DRIVE/BLANK) and the BLANK_CYC counter-width constant.
REQ-034 A combinational sub-module onehot_dec (parameter N; in addr[N-1:0], en; out y[2**N-1:0]) SHALL perform the decode.
REQ-035 The FSM, the dwell counter and the blank counter SHALL reside in decoder_scan.

Verification
REQ-036 N=3, direct mode, addr=5, raise en -> y=8'h20 one cycle later; active=1.
REQ-037 Direct mode, addr changes 5->2 while driving -> y=0 for exactly BLANK_CYC cycles, then 8'h04; y never has two bits set.
REQ-038 Scan mode, dwell=2, BLANK_CYC=1 -> y walks 8'h01..8'h80, each held 3 cycles with 1 zero cycle between; wrap pulses once per 32-cycle pass on the last 8'h80 cycle.
REQ-039 Scan mode, drop en while driving address 4 -> next cycle y=0, state IDLE, cur_addr=4; re-raise en -> scan restarts at 8'h01.
REQ-040 Assert rst_n low mid-BLANK -> y, cur_addr and wrap are 0 without waiting for a clock edge.
REQ-041 Switch mode 1->0 while driving address 6 with addr=1 -> BLANK, then y=8'h02.
